// File: rtl/burst_end_counter.sv
// Burst end counter: counts waveform periods after a trigger edge and issues
// a one-cycle end-of-burst pulse once the latched burst length is reached.
module burst_end_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK_Slow,
  input  logic             RST,
  input  logic             Trig_In,
  input  logic             Wrap_In,
  input  logic [CNT_W-1:0] Burst_Len,
  input  logic             EN_Burst,
  output logic             End_Sig_Out,
  output logic             Busy,
  output logic [CNT_W-1:0] Cycles_Done,
  output logic             Trig_Overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ENDP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             trig_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovr_nxt;
  logic             trig_rise_c;
  logic             last_wrap_c;

  assign trig_rise_c = Trig_In & ~trig_q;
  // Terminal wrap of a finite burst; length 0 means unbounded and never ends.
  assign last_wrap_c = (len_q != '0) && (Cycles_Done == (len_q - CNT_W'(1)));

  // Next-state, counter, latched length and overrun flag.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    cnt_nxt   = Cycles_Done;
    ovr_nxt   = Trig_Overrun;

    if (!EN_Burst) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trig_rise_c) begin
            state_nxt = RUN;
            len_nxt   = Burst_Len;
            cnt_nxt   = '0;
            ovr_nxt   = 1'b0;
          end
        end
        RUN: begin
          if (Wrap_In) begin
            cnt_nxt = Cycles_Done + CNT_W'(1);
            if (last_wrap_c) begin
              state_nxt = ENDP;
            end
          end
        end
        ENDP: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // A trigger edge seen while a burst is still active is dropped but flagged.
    if ((state != IDLE) && trig_rise_c) begin
      ovr_nxt = 1'b1;
    end
  end

  // State and registered outputs; outputs track the state being entered.
  always_ff @(posedge CLK_Slow) begin
    if (RST) begin
      state        <= IDLE;
      trig_q       <= 1'b0;
      len_q        <= '0;
      Cycles_Done  <= '0;
      Trig_Overrun <= 1'b0;
      End_Sig_Out  <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      trig_q       <= Trig_In;
      len_q        <= len_nxt;
      Cycles_Done  <= cnt_nxt;
      Trig_Overrun <= ovr_nxt;
      End_Sig_Out  <= (state_nxt == ENDP);
      Busy         <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_burst_end_counter.sv
// Directed bench for burst_end_counter with hand-computed expectations.
module tb_burst_end_counter;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             trig_in;
  logic             wrap_in;
  logic [CNT_W-1:0] burst_len;
  logic             en_burst;
  logic             end_sig;
  logic             busy;
  logic [CNT_W-1:0] cycles_done;
  logic             trig_overrun;

  int n_checks = 0;
  int n_pass   = 0;

  burst_end_counter #(.CNT_W(CNT_W)) dut (
    .CLK_Slow     (clk),
    .RST          (rst),
    .Trig_In      (trig_in),
    .Wrap_In      (wrap_in),
    .Burst_Len    (burst_len),
    .EN_Burst     (en_burst),
    .End_Sig_Out  (end_sig),
    .Busy         (busy),
    .Cycles_Done  (cycles_done),
    .Trig_Overrun (trig_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst();
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
  endtask

  task automatic wrap_once();
    wrap_in = 1'b1;
    tick();
    wrap_in = 1'b0;
    tick();
  endtask

  initial begin
    bit end_seen;
    bit busy_lost;

    rst       = 1'b1;
    trig_in   = 1'b0;
    wrap_in   = 1'b0;
    burst_len = '0;
    en_burst  = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_end", 32'(end_sig), 32'd0);
    check("rst_cnt", 32'(cycles_done), 32'd0);
    check("rst_ovr", 32'(trig_overrun), 32'd0);

    // 1: length 3, wraps at t0+5, +10, +15
    burst_len = 16'd3;
    start_burst();
    for (int k = 1; k <= 15; k++) begin
      wrap_in = (k % 5 == 0);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_end_low", 32'(end_sig), 32'd0);
      tick();
    end
    wrap_in = 1'b0;
    check("t1_end", 32'(end_sig), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_cnt", 32'(cycles_done), 32'd3);
    tick();
    check("t1_end_once", 32'(end_sig), 32'd0);

    // 2: unbounded, 70000 back-to-back wraps
    burst_len = 16'd0;
    start_burst();
    end_seen  = 1'b0;
    busy_lost = 1'b0;
    wrap_in   = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      tick();
      if (end_sig) end_seen = 1'b1;
      if (!busy) busy_lost = 1'b1;
    end
    wrap_in = 1'b0;
    check("t2_no_end", 32'(end_seen), 32'd0);
    check("t2_busy_held", 32'(busy_lost), 32'd0);
    check("t2_cnt", 32'(cycles_done), 32'd4464);
    en_burst = 1'b0;
    tick();
    check("t2_stop_busy", 32'(busy), 32'd0);
    check("t2_stop_end", 32'(end_sig), 32'd0);
    en_burst = 1'b1;

    // 3: length 4, second trigger after two wraps
    burst_len = 16'd4;
    start_burst();
    check("t3_ovr_clear", 32'(trig_overrun), 32'd0);
    wrap_once();
    wrap_once();
    start_burst();
    check("t3_ovr", 32'(trig_overrun), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_cnt_kept", 32'(cycles_done), 32'd2);
    wrap_once();
    check("t3_end_early", 32'(end_sig), 32'd0);
    wrap_in = 1'b1;
    tick();
    wrap_in = 1'b0;
    check("t3_end", 32'(end_sig), 32'd1);
    check("t3_cnt", 32'(cycles_done), 32'd4);
    check("t3_ovr_sticky", 32'(trig_overrun), 32'd1);
    tick();
    start_burst();
    check("t3_ovr_cleared", 32'(trig_overrun), 32'd0);
    check("t3_restart", 32'(busy), 32'd1);
    en_burst = 1'b0;
    tick();
    en_burst = 1'b1;

    // 4: length 5, enable dropped after two wraps
    burst_len = 16'd5;
    start_burst();
    wrap_once();
    wrap_once();
    en_burst = 1'b0;
    tick();
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_cnt", 32'(cycles_done), 32'd2);
    end_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wrap_in = 1'b1;
      tick();
      if (end_sig) end_seen = 1'b1;
    end
    wrap_in = 1'b0;
    check("t4_no_end", 32'(end_seen), 32'd0);
    check("t4_cnt_held", 32'(cycles_done), 32'd2);
    en_burst = 1'b1;

    // 5: reset in the middle of a burst
    burst_len = 16'd10;
    start_burst();
    for (int k = 0; k < 7; k++) wrap_once();
    check("t5_cnt7", 32'(cycles_done), 32'd7);
    start_burst();
    check("t5_ovr_pre", 32'(trig_overrun), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_end", 32'(end_sig), 32'd0);
    check("t5_cnt", 32'(cycles_done), 32'd0);
    check("t5_ovr", 32'(trig_overrun), 32'd0);
    start_burst();
    check("t5_restart", 32'(busy), 32'd1);
    check("t5_restart_cnt", 32'(cycles_done), 32'd0);
    en_burst = 1'b0;
    tick();
    en_burst = 1'b1;

    // 6: length 1, trigger and wrap together, length changed during run
    burst_len = 16'd1;
    trig_in   = 1'b1;
    wrap_in   = 1'b1;
    tick();
    trig_in   = 1'b0;
    wrap_in   = 1'b0;
    burst_len = 16'd5;
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_cnt0", 32'(cycles_done), 32'd0);
    tick();
    tick();
    check("t6_no_end", 32'(end_sig), 32'd0);
    wrap_in = 1'b1;
    tick();
    wrap_in = 1'b0;
    check("t6_end", 32'(end_sig), 32'd1);
    check("t6_cnt", 32'(cycles_done), 32'd1);
    check("t6_busy_end", 32'(busy), 32'd0);
    tick();
    check("t6_idle", 32'(end_sig), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
